// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port fixed-priority arbiter for the data memory.
// Optional DMEM_ARB_LOCK_EN adds p0_lock/p1_lock ownership locking.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   p{0,1}_req/we/addr/wd   requester access (byte address)
//   p{0,1}_gnt          combinational grant
//   p{0,1}_rvalid/rd/err    registered read return and error pulse
//   p{0,1}_lock         (DMEM_ARB_LOCK_EN only) hold exclusive ownership
//   mem_we/addr/wd/rd   single-port memory, combinational read
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned DEPTH        = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wd,
`ifdef DMEM_ARB_LOCK_EN
  input  logic        p0_lock,
`endif
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rd,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wd,
`ifdef DMEM_ARB_LOCK_EN
  input  logic        p1_lock,
`endif
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rd,
  output logic        p1_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] cnt_nx;
  logic          force1;
  logic          force1_nx;
  logic          p0_ok;
  logic          p1_ok;
  logic          own0;
  logic          own1;

  function automatic logic legal(input logic [31:0] a);
    logic [31:0] wa;
    wa = {2'b00, a[31:2]};
    return (a[1:0] == 2'b00) && (wa < 32'(DEPTH));
  endfunction

  assign p0_ok = legal(p0_addr);
  assign p1_ok = legal(p1_addr);

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  state_t state;
  state_t state_nx;

  // Ownership only holds while the owner keeps lock high; the
  // cycle it drops lock falls through to normal arbitration.
  assign own0 = (state == OWN0) && p0_lock;
  assign own1 = (state == OWN1) && p1_lock;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!own0 && !own1) begin
      state_nx = IDLE;
      if (p0_gnt && p0_lock) state_nx = OWN0;
      if (p1_gnt && p1_lock) state_nx = OWN1;
    end
  end
`else
  assign own0 = 1'b0;
  assign own1 = 1'b0;
`endif

  // Ownership outranks force1, so a starving p1 cannot break a p0 lock.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      if (own0)                 p0_gnt = p0_req;
      else if (own1)            p1_gnt = p1_req;
      else if (force1 && p1_req) p1_gnt = 1'b1;
      else if (p0_req)          p0_gnt = 1'b1;
      else                      p1_gnt = p1_req;
    end
  end

  always_comb begin
    mem_addr = p1_gnt ? p1_addr : p0_addr;
    mem_wd   = p1_gnt ? p1_wd   : p0_wd;
    mem_we   = (p0_gnt & p0_we & p0_ok) |
               (p1_gnt & p1_we & p1_ok);
  end

  always_comb begin
    cnt_nx    = starve_cnt;
    force1_nx = force1;
    if (!p1_req || p1_gnt) begin
      cnt_nx    = '0;
      force1_nx = 1'b0;
    end else begin
      if (starve_cnt != LIM) cnt_nx = starve_cnt + 1'b1;
      if (cnt_nx == LIM)     force1_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      force1     <= 1'b0;
      p0_rvalid  <= 1'b0;
      p0_rd      <= '0;
      p0_err     <= 1'b0;
      p1_rvalid  <= 1'b0;
      p1_rd      <= '0;
      p1_err     <= 1'b0;
    end else begin
      starve_cnt <= cnt_nx;
      force1     <= force1_nx;
      p0_rvalid  <= p0_gnt & ~p0_we;
      p0_err     <= p0_gnt & ~p0_ok;
      p1_rvalid  <= p1_gnt & ~p1_we;
      p1_err     <= p1_gnt & ~p1_ok;
      if (p0_gnt && !p0_we) p0_rd <= p0_ok ? mem_rd : '1;
      if (p1_gnt && !p1_we) p1_rd <= p1_ok ? mem_rd : '1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a queue scoreboard
// checking read returns and error pulses per port.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wd, p1_addr, p1_wd;
  logic        p0_gnt, p0_rvalid, p0_err;
  logic        p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rd, p1_rd;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
`ifdef DMEM_ARB_LOCK_EN
  logic        p0_lock, p1_lock;
`endif

  logic [31:0] mem [64];

  typedef struct {
    logic        isrd;
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int cyc = 0;
  int nchk = 0;
  int nfail = 0;

  dmem_arbiter #(.STARVE_LIMIT(4), .DEPTH(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .p0_req   (p0_req),
    .p0_we    (p0_we),
    .p0_addr  (p0_addr),
    .p0_wd    (p0_wd),
`ifdef DMEM_ARB_LOCK_EN
    .p0_lock  (p0_lock),
`endif
    .p0_gnt   (p0_gnt),
    .p0_rvalid(p0_rvalid),
    .p0_rd    (p0_rd),
    .p0_err   (p0_err),
    .p1_req   (p1_req),
    .p1_we    (p1_we),
    .p1_addr  (p1_addr),
    .p1_wd    (p1_wd),
`ifdef DMEM_ARB_LOCK_EN
    .p1_lock  (p1_lock),
`endif
    .p1_gnt   (p1_gnt),
    .p1_rvalid(p1_rvalid),
    .p1_rd    (p1_rd),
    .p1_err   (p1_err),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rd = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic set0(input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    p0_req = r; p0_we = w; p0_addr = a; p0_wd = d;
  endtask

  task automatic set1(input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    p1_req = r; p1_we = w; p1_addr = a; p1_wd = d;
  endtask

  task automatic push(input int p, input logic isrd,
                      input logic [31:0] rd, input logic err);
    exp_t e;
    e.isrd = isrd;
    e.rd   = rd;
    e.err  = err;
    e.cyc  = cyc + 1;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic mon(input int p, input logic v,
                     input logic [31:0] rd, input logic err);
    exp_t e;
    string pf;
    pf = $sformatf("p%0d", p);
    if ((p == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
      nchk++;
      nfail++;
      $display("FAIL %s_unexpected_resp got rvalid=%0b err=%0b exp none",
               pf, v, err);
    end else begin
      e = (p == 0) ? q0.pop_front() : q1.pop_front();
      chk({pf, "_rvalid"}, 32'(v), 32'(e.isrd));
      if (e.isrd) chk({pf, "_rd"}, rd, e.rd);
      chk({pf, "_err"}, 32'(err), 32'(e.err));
      chk({pf, "_resp_cycle"}, cyc, e.cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (p0_rvalid || p0_err) mon(0, p0_rvalid, p0_rd, p0_err);
      if (p1_rvalid || p1_err) mon(1, p1_rvalid, p1_rd, p1_err);
    end
  end

  initial begin
    rst = 1'b1;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
`ifdef DMEM_ARB_LOCK_EN
    p0_lock = 1'b0;
    p1_lock = 1'b0;
`endif
    repeat (2) @(negedge clk);

    // reset suppresses grants and writes
    set0(1, 1, 32'h8, 32'h1);
    #1;
    chk("rst_p0_gnt", 32'(p0_gnt), 0);
    chk("rst_p1_gnt", 32'(p1_gnt), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    @(negedge clk);
    rst = 1'b0;
    set0(0, 0, 0, 0);
    @(negedge clk);
    chk("rst_p0_rvalid", 32'(p0_rvalid), 0);
    chk("rst_p1_rvalid", 32'(p1_rvalid), 0);
    chk("rst_p0_err", 32'(p0_err), 0);
    chk("rst_p1_err", 32'(p1_err), 0);
    chk("rst_p0_rd", p0_rd, 0);
    chk("rst_p1_rd", p1_rd, 0);

    // p0 write then read
    set0(1, 1, 32'h8, 32'hDEADBEEF);
    #1;
    chk("wr_p0_gnt", 32'(p0_gnt), 1);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_addr", mem_addr, 32'h8);
    @(negedge clk);
    set0(1, 0, 32'h8, 0);
    #1;
    chk("rd_p0_gnt", 32'(p0_gnt), 1);
    chk("rd_mem_we", 32'(mem_we), 0);
    push(0, 1, 32'hDEADBEEF, 0);
    @(negedge clk);
    set0(0, 0, 0, 0);
    @(negedge clk);

    // starvation: p1 wins on its 5th and 10th requesting cycle
    for (int c = 1; c <= 10; c++) begin
      set0(1, 1, 32'h10, 32'(c));
      set1(1, 1, 32'h14, 32'h55);
      #1;
      chk($sformatf("starve_p0_gnt_c%0d", c), 32'(p0_gnt),
          (c == 5 || c == 10) ? 0 : 1);
      chk($sformatf("starve_p1_gnt_c%0d", c), 32'(p1_gnt),
          (c == 5 || c == 10) ? 1 : 0);
      @(negedge clk);
    end
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    @(negedge clk);

    // p1 misaligned write, then out-of-range read
    set1(1, 1, 32'h3, 32'h1234);
    #1;
    chk("mis_p1_gnt", 32'(p1_gnt), 1);
    chk("mis_mem_we", 32'(mem_we), 0);
    push(1, 0, 0, 1);
    @(negedge clk);
    set1(1, 0, 32'h100, 0);
    #1;
    chk("oor_p1_gnt", 32'(p1_gnt), 1);
    chk("oor_mem_we", 32'(mem_we), 0);
    push(1, 1, 32'hFFFFFFFF, 1);
    @(negedge clk);

    // p1 legal read of the word it wrote while starving
    set1(1, 0, 32'h14, 0);
    #1;
    chk("p1rd_gnt", 32'(p1_gnt), 1);
    push(1, 1, 32'h55, 0);
    @(negedge clk);
    set1(0, 0, 0, 0);

    // preload 1,2,3 then back-to-back reads
    for (int i = 0; i < 3; i++) begin
      set0(1, 1, 32'(4 * i), 32'(i + 1));
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      set0(1, 0, 32'(4 * i), 0);
      #1;
      chk($sformatf("b2b_gnt_%0d", i), 32'(p0_gnt), 1);
      push(0, 1, 32'(i + 1), 0);
      @(negedge clk);
    end
    set0(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("hold_p0_rvalid", 32'(p0_rvalid), 0);
    chk("hold_p0_rd", p0_rd, 3);

    // reset in the same cycle as a read: no grant, no rvalid
    rst = 1'b1;
    set0(1, 0, 32'h0, 0);
    #1;
    chk("midrst_p0_gnt", 32'(p0_gnt), 0);
    @(negedge clk);
    rst = 1'b0;
    set0(0, 0, 0, 0);
    @(negedge clk);
    chk("midrst_p0_rvalid", 32'(p0_rvalid), 0);

`ifdef DMEM_ARB_LOCK_EN
    // p1 takes a lock, p0 denied while it holds
    set1(1, 1, 32'h18, 32'h7);
    p1_lock = 1'b1;
    #1;
    chk("lock_p1_gnt0", 32'(p1_gnt), 1);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      set0(1, 1, 32'h1C, 32'h9);
      #1;
      chk($sformatf("lock_p0_den_%0d", c), 32'(p0_gnt), 0);
      chk($sformatf("lock_p1_gnt_%0d", c), 32'(p1_gnt), 1);
      @(negedge clk);
    end
    p1_lock = 1'b0;
    set1(0, 0, 0, 0);
    #1;
    chk("unlock_p0_gnt", 32'(p0_gnt), 1);
    @(negedge clk);
    set0(0, 0, 0, 0);
`endif

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the single-port data memory (64 x 32-bit words, word-addressed by addr[31:2], combinational read, write on posedge clk).
- Port 0 is the pipeline MEM stage and has fixed priority. Port 1 is a secondary master (loader/debug/DMA).
- Port 1 is protected from starvation by a bounded wait counter.
- Read data is registered, so each port sees a one-cycle read latency.

Parameters:
- STARVE_LIMIT, 4: consecutive denied cycles of a pending port-1 request after which port 1 is forced ahead of port 0 for one access.
- DEPTH, 64: number of memory words; used for the address range check.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- p0_req  in  1  port-0 access request
- p0_we  in  1  port-0 write enable (1 = write, 0 = read)
- p0_addr  in  32  port-0 byte address
- p0_wd  in  32  port-0 write data
- p0_gnt  out  1  port-0 request accepted this cycle (combinational)
- p0_rvalid  out  1  port-0 read data valid (registered)
- p0_rd  out  32  port-0 read data (registered)
- p0_err  out  1  port-0 access error pulse (registered)
- p1_req, p1_we, p1_addr, p1_wd, p1_gnt, p1_rvalid, p1_rd, p1_err: same widths and meanings for port 1
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory byte address
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory combinational read data

Behaviour:
- Reset: synchronous on posedge clk when rst=1.
  - All registered outputs clear: p*_rvalid=0, p*_rd=0, p*_err=0.
  - starve_cnt clears to 0 and force1 clears to 0.
  - While rst=1, p0_gnt=p1_gnt=0 and mem_we=0.
- Arbitration (combinational, every cycle):
  - force1=0: grant p0 if p0_req; else grant p1 if p1_req.
  - force1=1: grant p1 if p1_req; else p0 if p0_req.
  - At most one gnt high per cycle. A request with no gnt must be held stable by the requester until granted.
- Memory drive:
  - mem_addr and mem_wd mux from the granted port.
  - mem_we = granted port's we AND access is legal.
  - No grant: mem_addr = p0_addr, mem_wd = p0_wd, mem_we = 0.
- Legal access: addr[1:0]==0 and addr[31:2] < DEPTH.
  - Illegal write: suppressed (mem_we=0), gnt still given, that port's err=1 next cycle.
  - Illegal read: rvalid=1 next cycle, rd=32'hFFFFFFFF, err=1.
- Read return:
  - On a granted read, the port's rd register captures mem_rd at posedge and rvalid=1 in the following cycle for exactly one cycle.
  - Writes never raise rvalid.
  - Back-to-back reads give rvalid on consecutive cycles.
  - rd holds its value when rvalid=0.
- Starvation counter (saturating at STARVE_LIMIT):
  - Increments when p1_req=1 and p1_gnt=0. Clears when p1_gnt=1 or p1_req=0.
  - force1 is set on the posedge where starve_cnt reaches STARVE_LIMIT (i.e., force1 is high in the cycle after the STARVE_LIMIT-th denial).
  - force1 clears on the cycle p1 is granted, or if p1_req drops.
  - With STARVE_LIMIT=4 and p0 constantly requesting, p1 is granted on its 5th requesting cycle.
- Simultaneous events:
  - Both ports request the same address: only the granted one accesses. No merging or forwarding.
  - rst asserted mid-access: a grant in the same cycle as rst is suppressed, and no rvalid follows.
- Latency: grant 0 cycles from req when winning; read data 1 cycle after grant.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- With the macro defined:
  - Extra inputs p0_lock and p1_lock (1 bit each).
  - A port granted with lock=1 enters FSM state OWN0/OWN1 (from IDLE) and keeps exclusive ownership while it holds lock.
  - The other port is denied during ownership. Its starvation counter still counts, but force1 does not preempt an OWN0 lock.
  - The FSM returns to IDLE on the first cycle the owner's lock=0. That cycle is arbitrated normally.
  - rst returns the FSM to IDLE.
- Without the macro: no lock ports, no FSM; behaviour is exactly as above.

Test Plan:
- Reset: assert rst with p0_req=1 -> no gnt, mem_we=0; after release, all rvalid/err=0 and rd=0.
- p0 write addr 0x8 data 0xDEADBEEF, then p0 read 0x8 -> p0_gnt=1 both cycles; p0_rvalid=1 with p0_rd=0xDEADBEEF one cycle after the read grant.
- p0_req and p1_req held high, STARVE_LIMIT=4 -> p0 granted cycles 1-4, p1 granted cycle 5, p0 granted cycle 6; counter back to 0.
- p1 write addr 0x3 (misaligned), then p1 read 0x100 (word 64, out of range) -> both granted, no mem_we; p1_err pulses after each; the read returns rd=0xFFFFFFFF with rvalid=1.
- Back-to-back p0 reads 0x0, 0x4, 0x8 after preloading 1, 2, 3 -> rvalid high 3 consecutive cycles with rd 1, 2, 3.
- (DMEM_ARB_LOCK_EN) p1 lock for 3 cycles while p0 requests -> p0 denied 3 cycles, granted on the cycle p1_lock falls.
